// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint: fixed address, write delivery, read serving, SCL stretch
//
// Oversamples SCL/SDA on clk, detects START/STOP, acknowledges its own 7-bit
// address, hands written bytes to local logic and shifts out read bytes. The
// bus is only ever pulled low through open-drain enables; SCL is held low while
// local logic has no read byte ready.
//
// Ports:
//   clk       system clock (at least 8x SCL)
//   rst       synchronous, active-high reset
//   scl_i     bus SCL level, asynchronous
//   sda_i     bus SDA level, asynchronous
//   sda_oe    1 pulls SDA low
//   scl_oe    1 pulls SCL low (clock stretch)
//   rx_data   last byte written by the controller
//   rx_valid  one-cycle pulse when rx_data updates
//   tx_data   next byte to return on a read
//   tx_valid  tx_data is available
//   tx_ack    one-cycle pulse when tx_data is consumed
//   busy      addressed transaction in progress

module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42,
    parameter int         SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD,
        ST_RD_ACK
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC-1:0] scl_sync;
    logic [SYNC-1:0] sda_sync;
    logic            scl_s;
    logic            sda_s;
    logic            scl_d;
    logic            sda_d;

    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       acked;

    logic scl_rise;
    logic scl_fall;
    logic scl_high;
    logic bus_start;
    logic bus_stop;
    logic addr_hit;

    // Synchronizers reset to the idle bus level so that leaving reset never
    // fabricates an edge or a bus condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            if (SYNC > 1) begin
                scl_sync <= {scl_sync[SYNC-2:0], scl_i};
                sda_sync <= {sda_sync[SYNC-2:0], sda_i};
            end else begin
                scl_sync <= {SYNC{scl_i}};
                sda_sync <= {SYNC{sda_i}};
            end
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC-1];
    assign sda_s     = sda_sync[SYNC-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign scl_high  = scl_s & scl_d;
    assign bus_start = scl_high & sda_d & ~sda_s;
    assign bus_stop  = scl_high & ~sda_d & sda_s;

    // On the 8th address rise the seven address bits are the low seven bits
    // already shifted in; the incoming bit is R/W.
    assign addr_hit = (shreg[6:0] == ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bus conditions outrank any SCL edge seen in the same cycle.
    always_comb begin
        state_nx = state;
        if (bus_start) begin
            state_nx = ST_ADDR;
        end else if (bus_stop) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_IDLE;
                end
                ST_ADDR: begin
                    if (scl_rise && bit_cnt == 4'd7 && !addr_hit) begin
                        state_nx = ST_IDLE;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_nx = rw ? ST_RD_LOAD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_nx = ST_WR;
                    end
                end
                ST_RD_LOAD: begin
                    if (tx_valid) begin
                        state_nx = ST_RD;
                    end
                end
                ST_RD: begin
                    if (scl_fall && bit_cnt == 4'd7) begin
                        state_nx = ST_RD_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_nx = ST_IDLE;
                    end else if (scl_fall && acked) begin
                        state_nx = ST_RD_LOAD;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            acked    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bus_start) begin
                bit_cnt <= '0;
            end else if (bus_stop) begin
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                rw      <= sda_s;
                                busy    <= addr_hit;
                                bit_cnt <= addr_hit ? 4'd8 : 4'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                        end
                    end
                    ST_WR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shreg[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                        end
                    end
                    ST_RD_LOAD: begin
                        if (tx_valid) begin
                            shreg   <= tx_data;
                            bit_cnt <= '0;
                        end
                    end
                    ST_RD: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                acked   <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            acked <= ~sda_s;
                        end
                    end
                    default: begin
                        bit_cnt <= bit_cnt;
                    end
                endcase
            end
        end
    end

    // In RD_LOAD the first bit goes out in the same cycle the byte is taken,
    // so SCL is never released ahead of valid SDA.
    always_comb begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
        tx_ack = 1'b0;
        case (state)
            ST_ADDR_ACK, ST_WR_ACK: begin
                sda_oe = 1'b1;
            end
            ST_RD_LOAD: begin
                scl_oe = ~tx_valid;
                tx_ack = tx_valid;
                sda_oe = tx_valid & ~tx_data[7];
            end
            ST_RD: begin
                sda_oe = ~shreg[7];
            end
            default: begin
                sda_oe = 1'b0;
            end
        endcase
    end

endmodule
